// File: rtl/mem_stage.sv
// Memory pipeline stage: issues aligned big-endian loads/stores on a simple req/ack bus,
// detects alignment and overflow exceptions, and presents a registered writeback port.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        exvalid,
    input  logic        exload,
    input  logic        exstore,
    input  logic [1:0]  exsize,
    input  logic        exsigned,
    input  logic [63:0] exalur,
    input  logic [63:0] exstdata,
    input  logic        exovfl,
    input  logic [4:0]  exrd,
    input  logic        exwr,
    output logic        stall,
    output logic        memreq,
    output logic        memwr,
    output logic [31:0] memaddr,
    output logic [63:0] memwdata,
    output logic [7:0]  memwmask,
    input  logic        memack,
    input  logic [63:0] memrdata,
    output logic        wbvalid,
    output logic        wbwr,
    output logic [4:0]  wbrd,
    output logic [63:0] wbdata,
    output logic        excvalid,
    output logic [4:0]  exccause
);

    typedef enum logic {StIdle, StWait} state_t;

    state_t state_q, state_d;

    logic        ld_q, st_q, sgn_q, wr_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic [4:0]  rd_q;

    logic [2:0]  off;
    logic        misalign, ismem, start, go_mem;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] lshift, ldata;
    logic signed [63:0] sx;
    logic [5:0]  sh;

    assign off    = exalur[2:0];
    assign ismem  = exload | exstore;
    assign start  = (state_q == StIdle) && exvalid;
    assign go_mem = start && ismem && !exovfl && !misalign;

    // Lane 7 of the mask is byte offset 0, so lanes are selected by shifting right.
    always_comb begin
        misalign = 1'b0;
        wmask    = 8'h00;
        wdata    = 64'h0;
        unique case (exsize)
            2'd0: begin
                wmask = 8'h80 >> off;
                wdata = {8{exstdata[7:0]}};
            end
            2'd1: begin
                misalign = off[0];
                wmask    = 8'hC0 >> off;
                wdata    = {4{exstdata[15:0]}};
            end
            2'd2: begin
                misalign = |off[1:0];
                wmask    = 8'hF0 >> off;
                wdata    = {2{exstdata[31:0]}};
            end
            default: begin
                misalign = |off;
                wmask    = 8'hFF;
                wdata    = exstdata;
            end
        endcase
    end

    // Move the addressed field to the top, then shift back down to right-justify and extend.
    always_comb begin
        lshift = memrdata << {off_q, 3'b000};
        unique case (size_q)
            2'd0:    sh = 6'd56;
            2'd1:    sh = 6'd48;
            2'd2:    sh = 6'd32;
            default: sh = 6'd0;
        endcase
        sx    = $signed(lshift) >>> sh;
        ldata = sgn_q ? sx : (lshift >> sh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        memreq  = 1'b0;
        memwr   = 1'b0;
        unique case (state_q)
            StIdle: if (go_mem) state_d = StWait;
            StWait: begin
                stall  = 1'b1;
                memreq = 1'b1;
                memwr  = st_q;
                if (memack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            sgn_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= 3'd0;
            rd_q     <= 5'd0;
            memaddr  <= 32'h0;
            memwdata <= 64'h0;
            memwmask <= 8'h00;
            wbvalid  <= 1'b0;
            wbwr     <= 1'b0;
            wbrd     <= 5'd0;
            wbdata   <= 64'h0;
            excvalid <= 1'b0;
            exccause <= 5'd0;
        end else begin
            wbvalid  <= 1'b0;
            excvalid <= 1'b0;
            exccause <= 5'd0;
            if (start) begin
                ld_q   <= exload;
                st_q   <= exstore;
                sgn_q  <= exsigned;
                wr_q   <= exwr;
                size_q <= exsize;
                off_q  <= off;
                rd_q   <= exrd;
                wbrd   <= exrd;
                wbdata <= exalur;
                if (exovfl) begin
                    wbvalid  <= 1'b1;
                    wbwr     <= 1'b0;
                    excvalid <= 1'b1;
                    exccause <= 5'd12;
                end else if (ismem && misalign) begin
                    wbvalid  <= 1'b1;
                    wbwr     <= 1'b0;
                    excvalid <= 1'b1;
                    exccause <= exload ? 5'd4 : 5'd5;
                end else if (!ismem) begin
                    wbvalid <= 1'b1;
                    wbwr    <= exwr;
                end
                if (go_mem) begin
                    memaddr  <= {exalur[31:3], 3'b000};
                    memwdata <= exstore ? wdata : 64'h0;
                    memwmask <= exstore ? wmask : 8'h00;
                end
            end else if (state_q == StWait && memack) begin
                wbvalid <= 1'b1;
                wbwr    <= ld_q & wr_q;
                wbrd    <= rd_q;
                wbdata  <= ld_q ? ldata : 64'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks, a negedge monitor
// pops and compares each wbvalid pulse.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exvalid = 1'b0, exload = 1'b0, exstore = 1'b0, exsigned = 1'b0;
    logic [1:0]  exsize = 2'd0;
    logic [63:0] exalur = 64'h0, exstdata = 64'h0;
    logic        exovfl = 1'b0, exwr = 1'b0;
    logic [4:0]  exrd = 5'd0;
    logic        stall, memreq, memwr, memack = 1'b0;
    logic [31:0] memaddr;
    logic [63:0] memwdata, memrdata = 64'h0;
    logic [7:0]  memwmask;
    logic        wbvalid, wbwr, excvalid;
    logic [4:0]  wbrd, exccause;
    logic [63:0] wbdata;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        chkdata;
        logic        exc;
        logic [4:0]  cause;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .rst(rst), .exvalid(exvalid), .exload(exload), .exstore(exstore),
        .exsize(exsize), .exsigned(exsigned), .exalur(exalur), .exstdata(exstdata),
        .exovfl(exovfl), .exrd(exrd), .exwr(exwr), .stall(stall), .memreq(memreq),
        .memwr(memwr), .memaddr(memaddr), .memwdata(memwdata), .memwmask(memwmask),
        .memack(memack), .memrdata(memrdata), .wbvalid(wbvalid), .wbwr(wbwr), .wbrd(wbrd),
        .wbdata(wbdata), .excvalid(excvalid), .exccause(exccause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic wr, input logic [4:0] rd, input logic [63:0] data,
                             input logic chkdata, input logic exc, input logic [4:0] cause);
        exp_t e;
        e.wr = wr; e.rd = rd; e.data = data; e.chkdata = chkdata; e.exc = exc; e.cause = cause;
        q.push_back(e);
    endtask

    task automatic setop(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [63:0] alur, input logic [63:0] sdata, input logic ov,
                         input logic [4:0] rd, input logic wr);
        exload = ld; exstore = st; exsize = sz; exsigned = sg; exalur = alur;
        exstdata = sdata; exovfl = ov; exrd = rd; exwr = wr;
    endtask

    // Presents one instruction for exactly one edge (used only when the stage is idle).
    task automatic issue();
        exvalid = 1'b1;
        @(posedge clk);
        #1 exvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wbvalid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wbvalid: got wbrd=%0d wbdata=%h expected none",
                             wbrd, wbdata);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_wr", wbwr, e.wr);
                    chk("wb_rd", wbrd, e.rd);
                    chk("wb_excvalid", excvalid, e.exc);
                    chk("wb_exccause", exccause, e.cause);
                    if (e.chkdata) chk("wb_data", wbdata, e.data);
                end
            end else if (excvalid || exccause != 5'd0) begin
                checks++;
                errors++;
                $display("FAIL exc_without_wb: got excvalid=%0b cause=%0d expected 0/0",
                         excvalid, exccause);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_memreq", memreq, 0);
        chk("rst_memwr", memwr, 0);
        chk("rst_wbvalid", wbvalid, 0);
        chk("rst_wbwr", wbwr, 0);
        chk("rst_excvalid", excvalid, 0);
        chk("rst_memwmask", memwmask, 0);
        chk("rst_wbrd", wbrd, 0);
        chk("rst_exccause", exccause, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_memwdata", memwdata, 0);
        chk("rst_wbdata", wbdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU op
        setop(0, 0, 0, 0, 64'h1234, 0, 0, 5'd3, 1);
        expect_wb(1, 5'd3, 64'h1234, 1, 0, 0);
        issue();
        @(negedge clk);
        chk("alu_stall", stall, 0);
        chk("alu_wbvalid", wbvalid, 1);

        // Signed byte load at offset 5, ack in the third request cycle
        @(posedge clk); #1;
        setop(1, 0, 2'd0, 1, 64'h0000_0000_1000_0005, 0, 0, 5'd5, 1);
        expect_wb(1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        issue();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ldb_memreq", memreq, 1);
            chk("ldb_stall", stall, 1);
            chk("ldb_memwmask", memwmask, 0);
            chk("ldb_memwr", memwr, 0);
            if (i == 0) chk("ldb_memaddr", memaddr, 32'h1000_0000);
            if (i == 2) begin
                memack = 1'b1;
                memrdata = 64'h0011_2233_44FF_6677;
            end
        end
        @(posedge clk); #1 memack = 1'b0;
        @(negedge clk);
        chk("ldb_memreq_done", memreq, 0);
        chk("ldb_wbvalid", wbvalid, 1);

        // Half store at offset 2, zero-wait ack
        @(posedge clk); #1;
        setop(0, 1, 2'd1, 0, 64'h0000_0000_2000_000A, 64'hABCD, 0, 5'd7, 1);
        expect_wb(0, 5'd7, 0, 0, 0, 0);
        issue();
        @(negedge clk);
        chk("sth_memreq", memreq, 1);
        chk("sth_memwr", memwr, 1);
        chk("sth_memaddr", memaddr, 32'h2000_0008);
        chk("sth_memwmask", memwmask, 8'h30);
        chk("sth_memwdata", memwdata, 64'hABCD_ABCD_ABCD_ABCD);
        memack = 1'b1;
        @(posedge clk); #1 memack = 1'b0;

        // Byte store at offset 3
        setop(0, 1, 2'd0, 0, 64'h0000_0000_3000_0003, 64'h1122_335A, 0, 5'd8, 0);
        expect_wb(0, 5'd8, 0, 0, 0, 0);
        @(posedge clk); #1;
        issue();
        @(negedge clk);
        chk("stb_memwmask", memwmask, 8'h10);
        chk("stb_memwdata", memwdata, 64'h5A5A_5A5A_5A5A_5A5A);
        memack = 1'b1;
        @(posedge clk); #1 memack = 1'b0;

        // Dword store aligned
        setop(0, 1, 2'd3, 0, 64'h0000_0000_3000_0010, 64'h0102_0304_0506_0708, 0, 5'd9, 1);
        expect_wb(0, 5'd9, 0, 0, 0, 0);
        @(posedge clk); #1;
        issue();
        @(negedge clk);
        chk("std_memwmask", memwmask, 8'hFF);
        chk("std_memwdata", memwdata, 64'h0102_0304_0506_0708);
        chk("std_memaddr", memaddr, 32'h3000_0010);
        memack = 1'b1;
        @(posedge clk); #1 memack = 1'b0;

        // Misaligned word load
        @(posedge clk); #1;
        setop(1, 0, 2'd2, 0, 64'h0000_0000_4000_0006, 0, 0, 5'd10, 1);
        expect_wb(0, 5'd10, 0, 0, 1, 5'd4);
        issue();
        @(negedge clk);
        chk("mis_memreq", memreq, 0);
        chk("mis_stall", stall, 0);
        chk("mis_excvalid", excvalid, 1);

        // Overflow beats misaligned store
        @(posedge clk); #1;
        setop(0, 1, 2'd1, 0, 64'h0000_0000_4000_0001, 64'h55, 1, 5'd11, 1);
        expect_wb(0, 5'd11, 0, 0, 1, 5'd12);
        issue();
        @(negedge clk);
        chk("ovf_memreq", memreq, 0);
        chk("ovf_excvalid", excvalid, 1);

        // Reset during WAIT, then a stray ack
        @(posedge clk); #1;
        setop(1, 0, 2'd3, 0, 64'h0000_0000_5000_0000, 0, 0, 5'd12, 1);
        issue();
        @(negedge clk);
        chk("rw_memreq_before", memreq, 1);
        #2 rst = 1'b1;
        #1;
        chk("rw_memreq_async", memreq, 0);
        chk("rw_stall_async", stall, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 memack = 1'b1;
        @(posedge clk); #1 memack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_no_wbvalid", wbvalid, 0);
            chk("rw_no_memreq", memreq, 0);
        end

        // Back-to-back loads, memack tied high, EX holding exvalid through stall
        memrdata = 64'h8011_2233_44FF_6677;
        memack = 1'b1;
        expect_wb(1, 5'd13, 64'hFFFF_FFFF_8011_2233, 1, 0, 0);
        expect_wb(1, 5'd14, 64'h0000_0000_0000_44FF, 1, 0, 0);
        expect_wb(1, 5'd15, 64'h0000_0000_0000_0077, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            unique case (i)
                0: setop(1, 0, 2'd2, 1, 64'h0000_0000_6000_0000, 0, 0, 5'd13, 1);
                1: setop(1, 0, 2'd1, 0, 64'h0000_0000_6000_0004, 0, 0, 5'd14, 1);
                default: setop(1, 0, 2'd0, 0, 64'h0000_0000_6000_0007, 0, 0, 5'd15, 1);
            endcase
            exvalid = 1'b1;
            @(posedge clk); #1;
            chk("b2b_stall", stall, 1);
            @(posedge clk); #1;
            chk("b2b_stall_release", stall, 0);
            chk("b2b_wbvalid", wbvalid, 1);
        end
        exvalid = 1'b0;
        memack = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
